// File: rtl/rvm_mem_responder.sv
// Wait-state memory responder: a 32-bit word array behind a simple
// request/stall handshake, with per-byte writes and access-error reporting.
module rvm_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_c_en,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_b_en,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_error,
  output logic        mem_stall
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  ben_q, ben_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [31:0] mem_q [DEPTH];

  logic [31:0]      acc_addr;
  logic [3:0]       acc_ben;
  logic [31:0]      acc_wdata;
  logic [31:0]      word_off;
  logic             acc_err;
  logic [IDX_W-1:0] acc_idx;
  logic             enter_resp;
  logic             mem_we;

  // With zero wait states the access happens on the capture edge, so the
  // live bus is used instead of the not-yet-loaded capture registers.
  always_comb begin
    acc_addr  = (state_q == S_IDLE) ? mem_addr  : addr_q;
    acc_ben   = (state_q == S_IDLE) ? mem_b_en  : ben_q;
    acc_wdata = (state_q == S_IDLE) ? mem_wdata : wdata_q;
    word_off  = (acc_addr - BASE) >> 2;
    acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr < BASE) ||
                (word_off >= 32'(DEPTH));
    acc_idx   = word_off[IDX_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    ben_d      = ben_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_c_en) begin
          addr_d  = mem_addr;
          ben_d   = mem_b_en;
          wdata_d = mem_wdata;
          cnt_d   = WAIT_LD;
          if (WAIT_LD == 4'd0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!mem_c_en) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d    = S_RESP;
          cnt_d      = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      error_d = acc_err;
      rdata_d = (acc_err || (acc_ben != 4'b0000)) ? 32'h0 : mem_q[acc_idx];
    end
  end

  // resetn gates the write so a request held across reset cannot land.
  assign mem_we = resetn && enter_resp && !acc_err && (acc_ben != 4'b0000);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      ben_q   <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ben_q   <= ben_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_ben[i]) mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign mem_stall = mem_c_en && (state_q != S_RESP);
  assign mem_rdata = (state_q == S_RESP) ? rdata_q : 32'h0;
  assign mem_error = (state_q == S_RESP) ? error_q : 1'b0;

endmodule

// File: tb/tb_rvm_mem_responder.sv
// Directed bench for rvm_mem_responder: three instances cover zero, one and
// three wait states, with expected values worked out by hand.
module tb_rvm_mem_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        c_en  [3];
  logic [31:0] addr  [3];
  logic [3:0]  ben   [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        err   [3];
  logic        stall [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rvm_mem_responder #(.DEPTH(1024), .BASE(32'h0), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .resetn(resetn), .mem_c_en(c_en[0]), .mem_addr(addr[0]),
    .mem_b_en(ben[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]),
    .mem_error(err[0]), .mem_stall(stall[0]));

  rvm_mem_responder #(.DEPTH(16), .BASE(32'h100), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .resetn(resetn), .mem_c_en(c_en[1]), .mem_addr(addr[1]),
    .mem_b_en(ben[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]),
    .mem_error(err[1]), .mem_stall(stall[1]));

  rvm_mem_responder #(.DEPTH(64), .BASE(32'h0), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .resetn(resetn), .mem_c_en(c_en[2]), .mem_addr(addr[2]),
    .mem_b_en(ben[2]), .mem_wdata(wdata[2]), .mem_rdata(rdata[2]),
    .mem_error(err[2]), .mem_stall(stall[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Presents one request on instance k and follows it to its RESP cycle.
  task automatic access(input int k, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input int exp_cyc, input logic exp_init,
                        input logic [31:0] exp_rd, input logic exp_er, input bit keep,
                        input string tag);
    int n;
    addr[k] = a; ben[k] = be; wdata[k] = wd; c_en[k] = 1'b1;
    #1 check({tag, "_stall0"}, 32'(stall[k]), 32'(exp_init));
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (!stall[k]) break;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_cyc));
    check({tag, "_err"}, 32'(err[k]), 32'(exp_er));
    if (be == 4'b0000) check({tag, "_rdata"}, rdata[k], exp_rd);
    if (!keep) begin
      c_en[k] = 1'b0; ben[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
      @(posedge clk); #1;
      check({tag, "_idle_rd"}, rdata[k], 32'h0);
      check({tag, "_idle_er"}, 32'(err[k]), 32'h0);
    end
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [3:0] be,
                    input logic [31:0] wd, input int cyc, input logic exp_er, input string tag);
    access(k, a, be, wd, cyc, 1'b1, 32'h0, exp_er, 1'b0, tag);
  endtask

  task automatic rd(input int k, input logic [31:0] a, input int cyc,
                    input logic [31:0] exp_rd, input logic exp_er, input string tag);
    access(k, a, 4'h0, 32'h0, cyc, 1'b1, exp_rd, exp_er, 1'b0, tag);
  endtask

  initial begin
    resetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      c_en[k] = 1'b0; addr[k] = 32'h0; ben[k] = 4'h0; wdata[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_rdata", rdata[k], 32'h0);
      check("rst_err", 32'(err[k]), 32'h0);
      check("rst_stall", 32'(stall[k]), 32'h0);
    end
    c_en[0] = 1'b1;
    #1 check("rst_stall_req", 32'(stall[0]), 32'h1);
    c_en[0] = 1'b0;
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // one wait state, default geometry
    wr(0, 32'h10, 4'hF, 32'hDEADBEEF, 2, 1'b0, "w1_wr_full");
    rd(0, 32'h10, 2, 32'hDEADBEEF, 1'b0, "w1_rd_full");
    wr(0, 32'h10, 4'b0010, 32'h0000AB00, 2, 1'b0, "w1_wr_byte1");
    rd(0, 32'h10, 2, 32'hDEADABEF, 1'b0, "w1_rd_byte1");
    rd(0, 32'h12, 2, 32'h0, 1'b1, "w1_rd_misal");
    wr(0, 32'h12, 4'hF, 32'h11111111, 2, 1'b1, "w1_wr_misal");
    rd(0, 32'h10, 2, 32'hDEADABEF, 1'b0, "w1_rd_after_misal");
    wr(0, 32'h0, 4'hF, 32'h01234567, 2, 1'b0, "w1_wr_word0");
    rd(0, 32'h1000, 2, 32'h0, 1'b1, "w1_rd_top");
    wr(0, 32'h1000, 4'hF, 32'hFFFFFFFF, 2, 1'b1, "w1_wr_top");
    rd(0, 32'h0, 2, 32'h01234567, 1'b0, "w1_rd_word0");
    wr(0, 32'hFFC, 4'hF, 32'hA5A55A5A, 2, 1'b0, "w1_wr_last");
    rd(0, 32'hFFC, 2, 32'hA5A55A5A, 1'b0, "w1_rd_last");

    // three wait states, array at 0x100..0x13F
    wr(1, 32'h104, 4'hF, 32'hCAFEF00D, 4, 1'b0, "w3_wr");
    rd(1, 32'h104, 4, 32'hCAFEF00D, 1'b0, "w3_rd");
    wr(1, 32'h108, 4'hF, 32'hFFFFFFFF, 4, 1'b0, "w3_wr_ones");
    wr(1, 32'h108, 4'b1001, 32'h11223344, 4, 1'b0, "w3_wr_b30");
    rd(1, 32'h108, 4, 32'h11FFFF44, 1'b0, "w3_rd_b30");
    rd(1, 32'hFC, 4, 32'h0, 1'b1, "w3_rd_below");
    rd(1, 32'h140, 4, 32'h0, 1'b1, "w3_rd_above");
    wr(1, 32'h13C, 4'hF, 32'h0BADCAFE, 4, 1'b0, "w3_wr_last");
    rd(1, 32'h13C, 4, 32'h0BADCAFE, 1'b0, "w3_rd_last");

    // request withdrawn during the wait states
    addr[1] = 32'h104; ben[1] = 4'hF; wdata[1] = 32'h12345678; c_en[1] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    c_en[1] = 1'b0; ben[1] = 4'h0;
    #1 check("abort_stall", 32'(stall[1]), 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_resp_rd", rdata[1], 32'h0);
      check("abort_no_resp_er", 32'(err[1]), 32'h0);
    end
    rd(1, 32'h104, 4, 32'hCAFEF00D, 1'b0, "abort_readback");

    // reset during the wait states of a write
    addr[1] = 32'h104; ben[1] = 4'hF; wdata[1] = 32'h55555555; c_en[1] = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    check("rstw_stall", 32'(stall[1]), 32'h1);
    check("rstw_rdata", rdata[1], 32'h0);
    check("rstw_err", 32'(err[1]), 32'h0);
    repeat (2) @(posedge clk);
    #1 check("rstw_hold_stall", 32'(stall[1]), 32'h1);
    c_en[1] = 1'b0; ben[1] = 4'h0; wdata[1] = 32'h0;
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    rd(1, 32'h104, 4, 32'hCAFEF00D, 1'b0, "rstw_readback");

    // zero wait states, back-to-back reads
    wr(2, 32'h20, 4'hF, 32'hAAAA0001, 1, 1'b0, "w0_wr_a");
    wr(2, 32'h24, 4'hF, 32'hBBBB0002, 1, 1'b0, "w0_wr_b");
    access(2, 32'h20, 4'h0, 32'h0, 1, 1'b1, 32'hAAAA0001, 1'b0, 1'b1, "b2b_a");
    access(2, 32'h24, 4'h0, 32'h0, 2, 1'b0, 32'hBBBB0002, 1'b0, 1'b0, "b2b_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rvm_mem_responder.md
RVM_MEM_RESPONDER -- requirements
Module: rvm_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024; number of 32-bit words in the internal array.
REQ-002 SHALL have parameter BASE, default 32'h0000_0000; byte address of word 0, word-aligned.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, range 0-15; wait states inserted per access.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mem_c_en  input  1  request valid; held high by the initiator until mem_stall is low.
REQ-007 SHALL have port mem_addr  input  32  byte address of the request.
REQ-008 SHALL have port mem_b_en  input  4  byte enables; nonzero means write, 4'b0000 means full-word read.
REQ-009 SHALL have port mem_wdata  input  32  write data; byte i is bits 8i+7:8i.
REQ-010 SHALL have port mem_rdata  output  32  read data, valid only in the RESP cycle.
REQ-011 SHALL have port mem_error  output  1  access error flag, valid only in the RESP cycle.
REQ-012 SHALL have port mem_stall  output  1  high while an accepted request is incomplete.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, WAIT and RESP.
REQ-014 In IDLE with mem_c_en=1, SHALL capture addr, b_en and wdata, load the wait counter with WAIT_CYCLES, and go to WAIT; if WAIT_CYCLES=0, SHALL go directly to RESP.
REQ-015 In IDLE with mem_c_en=0, SHALL remain in IDLE.
REQ-016 In WAIT with mem_c_en=1, SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 1.
REQ-017 In WAIT with mem_c_en=0, SHALL abort to IDLE with no array write and no response.
REQ-018 On the edge entering RESP, SHALL perform the access: a write updates only the bytes with b_en[i]=1; a read registers the addressed word into the read-data register.
REQ-019 SHALL flag an error on entry to RESP if the captured addr[1:0] != 0, addr < BASE, or addr >= BASE+4*DEPTH.
REQ-020 On error, SHALL not write the array, SHALL register read data as 0, and SHALL register the error flag as 1.
REQ-021 SHALL compute the word index as (addr-BASE)>>2.
REQ-022 RESP SHALL last exactly one cycle and then go to IDLE unconditionally, whatever the value of mem_c_en.
REQ-023 SHALL drive mem_stall = mem_c_en AND (state != RESP), combinationally.
REQ-024 SHALL drive mem_rdata and mem_error from their registers in RESP, and SHALL drive both to 0 in all other states.
REQ-025 Latency: a request presented in cycle N SHALL complete (mem_stall=0) in cycle N+1+WAIT_CYCLES.
REQ-026 Back-to-back: if mem_c_en remains high after RESP, the IDLE cycle that follows SHALL accept a new request, giving one stall cycle of turnaround.
REQ-027 Read data SHALL always be the full 32-bit word, regardless of alignment within the array.

Reset
REQ-028 While resetn=0: state=IDLE, wait counter=0, read-data register=0, error register=0, captured request registers=0.
REQ-029 Reset outputs: mem_rdata=0 and mem_error=0; mem_stall SHALL follow REQ-023 with state=IDLE.
REQ-030 Array contents SHALL not be reset.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction; no pending write SHALL occur afterwards.

Verification
REQ-032 WAIT_CYCLES=1: write addr 0x10, b_en 4'hF, wdata 0xDEADBEEF -> stall high for 2 cycles, low in cycle 3, mem_error=0; then read 0x10 -> mem_rdata=0xDEADBEEF in the RESP cycle.
REQ-033 Partial write: b_en 4'b0010, wdata 0x0000AB00 to 0x10 -> subsequent read returns 0xDEADABEF.
REQ-034 Misaligned addr 0x12, and addr BASE+4*DEPTH -> mem_error=1, mem_rdata=0 in RESP; array unchanged.
REQ-035 WAIT_CYCLES=3: drop mem_c_en during WAIT of a write -> FSM returns to IDLE, no response; read-back shows the old data.
REQ-036 WAIT_CYCLES=0, two consecutive reads with mem_c_en held high -> each completes in 2 cycles with one turnaround cycle between.
REQ-037 Assert resetn=0 during WAIT of a write -> outputs 0, state IDLE, write not performed.
